// File: rtl/gnn_0_example_load.sv
`default_nettype none
// gnn_0_example_load: streams N 64-byte beats from DRAM into one of two on-chip buffers,
// splitting the read into AXI bursts of at most 16 beats that never cross a 4 KB page.
module gnn_0_example_load (
   input  logic         aclk,
   input  logic         areset,
   input  logic         ap_start,
   output logic         ap_done,
   input  logic [63:0]  ctrl_addr_offset,
   input  logic [127:0] ctrl_instruction,
   output logic         m_axi_arvalid,
   input  logic         m_axi_arready,
   output logic [63:0]  m_axi_araddr,
   output logic [7:0]   m_axi_arlen,
   input  logic         m_axi_rvalid,
   output logic         m_axi_rready,
   input  logic [511:0] m_axi_rdata,
   input  logic         m_axi_rlast,
   output logic         load_write_buffer_1_wen,
   output logic [10:0]  load_write_buffer_1_addr,
   output logic [511:0] load_write_buffer_1_data,
   output logic         load_write_buffer_2_wen,
   output logic [10:0]  load_write_buffer_2_addr,
   output logic [511:0] load_write_buffer_2_data
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   state_t         state_q, state_d;
   logic [63:0]    next_addr_q;
   logic [15:0]    issue_rem_q, recv_rem_q, recv_rem_d;
   logic [2:0]     outst_q, outst_d;
   logic [3:0]     len_fifo_q [4];
   logic [1:0]     fifo_wr_q, fifo_rd_q;
   logic [3:0]     head_cnt_q;
   logic [10:0]    wr_addr_q;
   logic           sel_q;
   logic           arvalid_q, rready_q, ap_done_q, wen1_q, wen2_q;
   logic [63:0]    araddr_q;
   logic [7:0]     arlen_q;
   logic [10:0]    buf_addr_q;
   logic [511:0]   buf_data_q;

   logic           ar_hs, r_hs, burst_done, can_issue;
   logic [15:0]    start_n;
   logic [63:0]    start_base;
   logic [6:0]     beats_to_4k;
   logic [4:0]     len_cap, burst_len;
   logic           unused_bits;

   assign start_n     = ctrl_instruction[95:80];
   assign start_base  = (ctrl_addr_offset + {32'd0, ctrl_instruction[127:96]}) & ~64'h3F;
   assign unused_bits = ^{m_axi_rlast, ctrl_instruction[79:43], ctrl_instruction[31:1]};

   assign ar_hs      = arvalid_q & m_axi_arready;
   assign r_hs       = m_axi_rvalid & rready_q;
   // Bursts return in order, so the FIFO head is always the burst currently receiving data.
   assign burst_done = r_hs && (outst_q != 3'd0) && (head_cnt_q == len_fifo_q[fifo_rd_q]);
   assign outst_d    = outst_q + {2'b00, ar_hs} - {2'b00, burst_done};
   assign recv_rem_d = (r_hs && (recv_rem_q != 16'd0)) ? recv_rem_q - 16'd1 : recv_rem_q;

   assign beats_to_4k = 7'd64 - {1'b0, next_addr_q[11:6]};
   assign len_cap     = (issue_rem_q > 16'd16) ? 5'd16 : issue_rem_q[4:0];
   assign burst_len   = ({2'b00, len_cap} > beats_to_4k) ? beats_to_4k[4:0] : len_cap;
   assign can_issue   = (state_q == ISSUE) && (!arvalid_q || ar_hs) &&
                        (issue_rem_q != 16'd0) && (outst_d < 3'd4);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ap_start) state_d = (start_n == 16'd0) ? DONE : ISSUE;
         ISSUE:   if (ar_hs && (issue_rem_q == 16'd0))
                     state_d = (recv_rem_d == 16'd0) ? DONE : DRAIN;
         DRAIN:   if (recv_rem_d == 16'd0) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge areset) begin
      if (!areset) begin
         state_q     <= IDLE;
         next_addr_q <= '0;
         issue_rem_q <= '0;
         recv_rem_q  <= '0;
         outst_q     <= '0;
         for (int i = 0; i < 4; i++) len_fifo_q[i] <= '0;
         fifo_wr_q   <= '0;
         fifo_rd_q   <= '0;
         head_cnt_q  <= '0;
         wr_addr_q   <= '0;
         sel_q       <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         ap_done_q   <= 1'b0;
         wen1_q      <= 1'b0;
         wen2_q      <= 1'b0;
         araddr_q    <= '0;
         arlen_q     <= '0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ap_done_q  <= (state_q == DONE);
         rready_q   <= (state_d == ISSUE) || (state_d == DRAIN);
         outst_q    <= outst_d;
         recv_rem_q <= recv_rem_d;

         wen1_q <= 1'b0;
         wen2_q <= 1'b0;
         if (r_hs && (recv_rem_q != 16'd0)) begin
            wen1_q     <= ~sel_q;
            wen2_q     <= sel_q;
            buf_addr_q <= wr_addr_q;
            buf_data_q <= m_axi_rdata;
            wr_addr_q  <= wr_addr_q + 11'd1;
         end

         if (burst_done) begin
            fifo_rd_q  <= fifo_rd_q + 2'd1;
            head_cnt_q <= 4'd0;
         end else if (r_hs && (outst_q != 3'd0)) begin
            head_cnt_q <= head_cnt_q + 4'd1;
         end

         if (ar_hs) begin
            len_fifo_q[fifo_wr_q] <= arlen_q[3:0];
            fifo_wr_q             <= fifo_wr_q + 2'd1;
         end

         // A new burst may be presented in the same cycle the previous one is accepted.
         if (can_issue) begin
            arvalid_q   <= 1'b1;
            araddr_q    <= next_addr_q;
            arlen_q     <= {3'b000, burst_len - 5'd1};
            next_addr_q <= next_addr_q + {53'd0, burst_len, 6'd0};
            issue_rem_q <= issue_rem_q - {11'd0, burst_len};
         end else if (ar_hs) begin
            arvalid_q <= 1'b0;
         end

         if ((state_q == IDLE) && ap_start) begin
            next_addr_q <= start_base;
            issue_rem_q <= start_n;
            recv_rem_q  <= start_n;
            wr_addr_q   <= ctrl_instruction[42:32];
            sel_q       <= ctrl_instruction[0];
            fifo_wr_q   <= 2'd0;
            fifo_rd_q   <= 2'd0;
            head_cnt_q  <= 4'd0;
            outst_q     <= 3'd0;
         end
      end
   end

   assign ap_done                  = ap_done_q;
   assign m_axi_arvalid            = arvalid_q;
   assign m_axi_araddr             = araddr_q;
   assign m_axi_arlen              = arlen_q;
   assign m_axi_rready             = rready_q;
   assign load_write_buffer_1_wen  = wen1_q;
   assign load_write_buffer_1_addr = buf_addr_q;
   assign load_write_buffer_1_data = buf_data_q;
   assign load_write_buffer_2_wen  = wen2_q;
   assign load_write_buffer_2_addr = buf_addr_q;
   assign load_write_buffer_2_data = buf_data_q;

endmodule
`default_nettype wire

// File: tb/tb_gnn_0_example_load.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for gnn_0_example_load: bench acts as AXI read slave and
// compares bursts and buffer writes against a burst-splitting reference model.
module tb_gnn_0_example_load;

   logic         aclk = 1'b0;
   logic         areset, ap_start, ap_done;
   logic [63:0]  ctrl_addr_offset;
   logic [127:0] ctrl_instruction;
   logic         m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
   logic [63:0]  m_axi_araddr;
   logic [7:0]   m_axi_arlen;
   logic [511:0] m_axi_rdata;
   logic         wen1, wen2;
   logic [10:0]  addr1, addr2;
   logic [511:0] data1, data2;

   gnn_0_example_load dut (
      .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_done(ap_done),
      .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
      .load_write_buffer_1_wen(wen1), .load_write_buffer_1_addr(addr1),
      .load_write_buffer_1_data(data1),
      .load_write_buffer_2_wen(wen2), .load_write_buffer_2_addr(addr2),
      .load_write_buffer_2_data(data2)
   );

   always #5 aclk = ~aclk;

   int errors = 0;
   int checks = 0;

   typedef struct packed { logic [63:0] addr; logic [7:0] len; } ar_t;
   typedef struct packed { logic sel; logic [10:0] addr; logic [511:0] data; } wr_t;

   ar_t          got_ar[$];
   wr_t          got_wr[$];
   logic [511:0] sent[$];
   int           done_at[$];
   int           max_outst, ar_at_hold;
   logic         arvalid_at_hold, any_arvalid;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Reserved instruction bits are filled with noise; the DUT must ignore them.
   function automatic logic [127:0] mk_instr(logic [31:0] off, logic [15:0] n,
                                             logic [10:0] start, logic sel);
      logic [127:0] v;
      v = {$urandom, $urandom, $urandom, $urandom};
      v[127:96] = off;
      v[95:80]  = n;
      v[42:32]  = start;
      v[0]      = sel;
      return v;
   endfunction

   // Reference: split N beats into bursts of min(remaining, 16, beats to next 4 KB page).
   task automatic model_ars(input logic [63:0] ctrl, input logic [31:0] off, input int n,
                            output ar_t q[$]);
      logic [63:0] a;
      int rem, l, room;
      q.delete();
      a = ctrl + {32'd0, off};
      a[5:0] = 6'd0;
      rem = n;
      while (rem > 0) begin
         room = (4096 - int'(a[11:0])) / 64;
         l = rem;
         if (l > 16) l = 16;
         if (l > room) l = room;
         q.push_back({a, 8'(l - 1)});
         a = a + 64'(l * 64);
         rem -= l;
      end
   endtask

   // AXI read slave + output monitor; t counts clock edges since ap_start was raised.
   task automatic run_xfer(input logic [63:0] ctrl, input logic [127:0] instr, input int ar_pct,
                           input int hold, input int r_pct, input int cycles_max, input bit spam);
      int pend_len[$];
      logic [511:0] beats[$];
      int tail;
      got_ar.delete(); got_wr.delete(); sent.delete(); done_at.delete();
      max_outst = 0; ar_at_hold = -1; arvalid_at_hold = 1'b0; any_arvalid = 1'b0;
      ctrl_addr_offset = ctrl;
      ctrl_instruction = instr;
      ap_start = 1'b1;
      tail = -1;
      for (int t = 0; t < cycles_max; t++) begin
         if (t > 0) begin
            ap_start = (spam && m_axi_rready) ? 1'($urandom_range(1)) : 1'b0;
            if (spam) ctrl_instruction = {$urandom, $urandom, $urandom, $urandom};
         end
         if (wen1) got_wr.push_back({1'b0, addr1, data1});
         if (wen2) got_wr.push_back({1'b1, addr2, data2});
         if (ap_done) done_at.push_back(t);
         if (m_axi_arvalid) any_arvalid = 1'b1;
         if (t == hold) begin
            ar_at_hold = got_ar.size();
            arvalid_at_hold = m_axi_arvalid;
         end
         if (beats.size() > 0 && t >= hold && $urandom_range(99) < r_pct) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = beats[0];
            m_axi_rlast  = (pend_len[0] == 1);
         end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = rand512();
            m_axi_rlast  = 1'b0;
         end
         m_axi_arready = ($urandom_range(99) < ar_pct);
         if (m_axi_arvalid && m_axi_arready) begin
            got_ar.push_back({m_axi_araddr, m_axi_arlen});
            pend_len.push_back(int'(m_axi_arlen) + 1);
            for (int b = 0; b <= int'(m_axi_arlen); b++) beats.push_back(rand512());
         end
         if (m_axi_rvalid && m_axi_rready) begin
            sent.push_back(beats.pop_front());
            pend_len[0] = pend_len[0] - 1;
            if (pend_len[0] == 0) void'(pend_len.pop_front());
         end
         if (pend_len.size() > max_outst) max_outst = pend_len.size();
         if (done_at.size() > 0 && tail < 0) tail = 4;
         if (tail > 0) tail--;
         if (tail == 0) break;
         tick();
      end
      ap_start = 1'b0;
      m_axi_rvalid = 1'b0;
      m_axi_arready = 1'b0;
   endtask

   task automatic test_reset();
      #3 areset = 1'b0;
      #4;
      checks++;
      if ({m_axi_arvalid, m_axi_rready, ap_done, wen1, wen2} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 00000", {m_axi_arvalid, m_axi_rready, ap_done, wen1, wen2});
      end
      checks++;
      if (m_axi_araddr !== 64'd0 || m_axi_arlen !== 8'd0) begin
         errors++;
         $display("FAIL reset_ar: got addr=%h len=%h want 0", m_axi_araddr, m_axi_arlen);
      end
      checks++;
      if (addr1 !== 11'd0 || addr2 !== 11'd0 || data1 !== '0 || data2 !== '0) begin
         errors++;
         $display("FAIL reset_buf: got addr1=%0d addr2=%0d (data nonzero?) want 0", addr1, addr2);
      end
      tick();
      tick();
      areset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      wr_t exp_w;
      run_xfer(64'h1000, mk_instr(32'h100, 16'd4, 11'd5, 1'b0), 100, 0, 100, 200, 1'b0);
      checks++;
      if (got_ar.size() != 1 || got_ar[0] !== {64'h1100, 8'd3}) begin
         errors++;
         $display("FAIL basic_ar: got %0d bursts first=%h want 1 burst 1100/03", got_ar.size(),
                  got_ar.size() > 0 ? got_ar[0] : '0);
      end
      checks++;
      if (got_wr.size() != 4) begin
         errors++; $display("FAIL basic_wr_count: got %0d want 4", got_wr.size());
      end
      for (int k = 0; k < got_wr.size() && k < sent.size(); k++) begin
         exp_w = {1'b0, 11'(5 + k), sent[k]};
         checks++;
         if (got_wr[k] !== exp_w) begin
            errors++;
            $display("FAIL basic_wr[%0d]: got sel=%0d addr=%0d data=%h want sel=0 addr=%0d data=%h",
                     k, got_wr[k].sel, got_wr[k].addr, got_wr[k].data[31:0], 5 + k, sent[k][31:0]);
         end
      end
      checks++;
      if (done_at.size() != 1) begin
         errors++; $display("FAIL basic_done: got %0d pulses want 1", done_at.size());
      end
   endtask

   task automatic test_4k_split();
      ar_t exp_a[4];
      wr_t exp_w;
      int start;
      start = $urandom_range(2047);
      exp_a[0] = {64'h0F00, 8'd3};
      exp_a[1] = {64'h1000, 8'd15};
      exp_a[2] = {64'h1400, 8'd15};
      exp_a[3] = {64'h1800, 8'd3};
      run_xfer(64'h0, mk_instr(32'hF00, 16'd40, 11'(start), 1'b1), 70, 0, 80, 1000, 1'b0);
      checks++;
      if (got_ar.size() != 4) begin
         errors++; $display("FAIL split_ar_count: got %0d want 4", got_ar.size());
      end
      for (int i = 0; i < 4 && i < got_ar.size(); i++) begin
         checks++;
         if (got_ar[i] !== exp_a[i]) begin
            errors++;
            $display("FAIL split_ar[%0d]: got %h/%0d want %h/%0d", i, got_ar[i].addr, got_ar[i].len,
                     exp_a[i].addr, exp_a[i].len);
         end
      end
      checks++;
      if (got_wr.size() != 40) begin
         errors++; $display("FAIL split_wr_count: got %0d want 40", got_wr.size());
      end
      for (int k = 0; k < got_wr.size() && k < sent.size(); k++) begin
         exp_w = {1'b1, 11'((start + k) % 2048), sent[k]};
         checks++;
         if (got_wr[k] !== exp_w) begin
            errors++;
            $display("FAIL split_wr[%0d]: got sel=%0d addr=%0d want sel=1 addr=%0d", k,
                     got_wr[k].sel, got_wr[k].addr, (start + k) % 2048);
         end
      end
      checks++;
      if (done_at.size() != 1) begin
         errors++; $display("FAIL split_done: got %0d pulses want 1", done_at.size());
      end
   endtask

   task automatic test_wrap();
      int exp_addr[3] = '{2046, 2047, 0};
      logic sel;
      sel = 1'($urandom_range(1));
      run_xfer(64'h2000, mk_instr(32'h40, 16'd3, 11'd2046, sel), 100, 0, 100, 200, 1'b0);
      checks++;
      if (got_wr.size() != 3) begin
         errors++; $display("FAIL wrap_wr_count: got %0d want 3", got_wr.size());
      end
      for (int k = 0; k < 3 && k < got_wr.size() && k < sent.size(); k++) begin
         checks++;
         if (got_wr[k] !== {sel, 11'(exp_addr[k]), sent[k]}) begin
            errors++;
            $display("FAIL wrap_wr[%0d]: got sel=%0d addr=%0d want sel=%0d addr=%0d", k,
                     got_wr[k].sel, got_wr[k].addr, sel, exp_addr[k]);
         end
      end
   endtask

   task automatic test_zero();
      run_xfer(64'h5000, mk_instr(32'h0, 16'd0, 11'd9, 1'b0), 100, 0, 100, 50, 1'b0);
      checks++;
      if (done_at.size() != 1 || done_at[0] != 2) begin
         errors++;
         $display("FAIL zero_done: got %0d pulses first at %0d want 1 pulse at 2", done_at.size(),
                  done_at.size() > 0 ? done_at[0] : -1);
      end
      checks++;
      if (any_arvalid || got_wr.size() != 0) begin
         errors++;
         $display("FAIL zero_activity: got arvalid=%0d writes=%0d want 0 0", any_arvalid, got_wr.size());
      end
   endtask

   task automatic test_outstanding();
      ar_t exp_a[$];
      wr_t exp_w;
      model_ars(64'h0, 32'h0, 96, exp_a);
      run_xfer(64'h0, mk_instr(32'h0, 16'd96, 11'd100, 1'b0), 100, 30, 60, 3000, 1'b0);
      checks++;
      if (ar_at_hold != 4 || arvalid_at_hold !== 1'b0) begin
         errors++;
         $display("FAIL outst_hold: got %0d ARs arvalid=%0d want 4 ARs arvalid=0", ar_at_hold, arvalid_at_hold);
      end
      checks++;
      if (max_outst > 4) begin
         errors++; $display("FAIL outst_max: got %0d want <=4", max_outst);
      end
      checks++;
      if (got_ar != exp_a) begin
         errors++; $display("FAIL outst_ars: got %0d bursts want %0d", got_ar.size(), exp_a.size());
      end
      checks++;
      if (got_wr.size() != 96) begin
         errors++; $display("FAIL outst_wr_count: got %0d want 96", got_wr.size());
      end
      for (int k = 0; k < got_wr.size() && k < sent.size(); k++) begin
         exp_w = {1'b0, 11'(100 + k), sent[k]};
         checks++;
         if (got_wr[k] !== exp_w) begin
            errors++;
            $display("FAIL outst_wr[%0d]: got sel=%0d addr=%0d want sel=0 addr=%0d", k,
                     got_wr[k].sel, got_wr[k].addr, 100 + k);
         end
      end
      checks++;
      if (done_at.size() != 1) begin
         errors++; $display("FAIL outst_done: got %0d pulses want 1", done_at.size());
      end
   endtask

   task automatic test_reset_abort();
      int bad;
      ar_t exp_a[$];
      run_xfer(64'h0, mk_instr(32'hF00, 16'd40, 11'd0, 1'b1), 100, 0, 100, 12, 1'b0);
      areset = 1'b0;
      #2;
      checks++;
      if ({m_axi_arvalid, m_axi_rready, ap_done, wen1, wen2} !== 5'b0 ||
          m_axi_araddr !== 64'd0 || m_axi_arlen !== 8'd0) begin
         errors++;
         $display("FAIL abort_rst_ctrl: got %b addr=%h len=%h want all 0",
                  {m_axi_arvalid, m_axi_rready, ap_done, wen1, wen2}, m_axi_araddr, m_axi_arlen);
      end
      checks++;
      if (addr1 !== 11'd0 || data2 !== '0) begin
         errors++; $display("FAIL abort_rst_buf: got addr=%0d want 0 (and zero data)", addr1);
      end
      bad = 0;
      m_axi_rvalid = 1'b1;
      m_axi_rdata = rand512();
      repeat (3) begin
         tick();
         if (wen1 || wen2) bad++;
      end
      areset = 1'b1;
      repeat (4) begin
         tick();
         if (wen1 || wen2 || m_axi_rready) bad++;
      end
      m_axi_rvalid = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL abort_stray: got %0d cycles with wen/rready want 0", bad);
      end
      model_ars(64'h3000, 32'h80, 2, exp_a);
      run_xfer(64'h3000, mk_instr(32'h80, 16'd2, 11'd7, 1'b0), 100, 0, 100, 200, 1'b0);
      checks++;
      if (got_ar != exp_a) begin
         errors++; $display("FAIL abort_ars: got %0d bursts want %0d", got_ar.size(), exp_a.size());
      end
      checks++;
      if (got_wr.size() != 2 || sent.size() != 2 || got_wr[0] !== {1'b0, 11'd7, sent[0]} ||
          got_wr[1] !== {1'b0, 11'd8, sent[1]}) begin
         errors++; $display("FAIL abort_next_wr: got %0d writes want 2 at 7,8", got_wr.size());
      end
      checks++;
      if (done_at.size() != 1) begin
         errors++; $display("FAIL abort_next_done: got %0d pulses want 1", done_at.size());
      end
   endtask

   task automatic test_random();
      ar_t exp_a[$];
      logic [63:0] ctrl;
      logic [31:0] off;
      int n, start, bad;
      logic sel;
      for (int it = 0; it < 4; it++) begin
         ctrl  = {24'd0, $urandom, 8'($urandom)};
         off   = $urandom_range(32'h000F_FFFF);
         n     = $urandom_range(70, 1);
         start = $urandom_range(2047);
         sel   = 1'($urandom_range(1));
         model_ars(ctrl, off, n, exp_a);
         run_xfer(ctrl, mk_instr(off, 16'(n), 11'(start), sel), $urandom_range(100, 40), 0,
                  $urandom_range(100, 40), 3000, 1'b1);
         checks++;
         if (got_ar != exp_a) begin
            errors++;
            $display("FAIL rand%0d_ars: got %0d bursts want %0d (n=%0d base=%h)", it, got_ar.size(),
                     exp_a.size(), n, ctrl + {32'd0, off});
         end
         bad = 0;
         for (int k = 0; k < got_wr.size() && k < sent.size(); k++)
            if (got_wr[k] !== {sel, 11'((start + k) % 2048), sent[k]}) bad++;
         checks++;
         if (got_wr.size() != n || bad != 0) begin
            errors++;
            $display("FAIL rand%0d_wr: got %0d writes %0d wrong want %0d writes 0 wrong", it,
                     got_wr.size(), bad, n);
         end
         checks++;
         if (done_at.size() != 1 || max_outst > 4) begin
            errors++;
            $display("FAIL rand%0d_done: got %0d pulses max_outst=%0d want 1 and <=4", it,
                     done_at.size(), max_outst);
         end
      end
   endtask

   initial begin
      areset = 1'b1;
      ap_start = 1'b0;
      ctrl_addr_offset = '0;
      ctrl_instruction = '0;
      m_axi_arready = 1'b0;
      m_axi_rvalid = 1'b0;
      m_axi_rdata = '0;
      m_axi_rlast = 1'b0;
      test_reset();
      test_basic();
      test_4k_split();
      test_wrap();
      test_zero();
      test_outstanding();
      test_reset_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gnn_0_example_load.md
GNN_0_EXAMPLE_LOAD -- requirements
Module: gnn_0_example_load

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; every port SHALL be exactly as listed below:
- aclk  in  1  sole clock, rising edge.
- areset  in  1  asynchronous active-low reset.
- ap_start  in  1  one-cycle start pulse.
- ap_done  out  1  one-cycle completion pulse.
- ctrl_addr_offset  in  64  DRAM base byte address.
- ctrl_instruction  in  128  load instruction, sampled when ap_start is accepted.
- m_axi_arvalid  out  1  read-address valid.
- m_axi_arready  in  1  read-address ready.
- m_axi_araddr  out  64  burst byte address.
- m_axi_arlen  out  8  burst beats minus 1.
- m_axi_rvalid  in  1  read-data valid.
- m_axi_rready  out  1  read-data ready.
- m_axi_rdata  in  512  read data.
- m_axi_rlast  in  1  last beat of burst; ignored.
- load_write_buffer_1_wen  out  1  buffer-1 write enable.
- load_write_buffer_1_addr  out  11  buffer-1 word address.
- load_write_buffer_1_data  out  512  buffer-1 write data.
- load_write_buffer_2_wen, load_write_buffer_2_addr, load_write_buffer_2_data  out  1/11/512  same meaning for buffer 2.

REQ-002 Instruction fields SHALL be:
- [127:96] DRAM byte offset.
- [95:80] beat count N; each beat is 64 B.
- [47:32] buffer start word; bits [42:32] are used.
- [0] buffer select: 0 = buffer 1, 1 = buffer 2.
- All other bits reserved and ignored.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE; reset SHALL force IDLE.

REQ-004 ap_start SHALL be accepted only in IDLE, ignored in every other state. On acceptance the block SHALL latch:
- the instruction;
- base = ctrl_addr_offset + offset, with bits [5:0] forced to 0.
Next state SHALL be ISSUE, or DONE if N = 0.

REQ-005 In ISSUE the block SHALL issue bursts back-to-back:
- Burst length L = min(remaining beats, 16, beats left before the next 4 KB boundary).
- m_axi_arlen = L-1; m_axi_araddr advances by L*64 per burst.
- Each burst occupies exactly one AR handshake.

REQ-006 Outstanding bursts (AR accepted, data beats not all received) SHALL never exceed 4; arvalid SHALL deassert at the limit.

REQ-007 Once asserted, arvalid and araddr/arlen SHALL hold stable until arready.

REQ-008 Exit from ISSUE:
- after the final burst's AR handshake, go to DRAIN;
- if all beats have already been received, go directly to DONE.

REQ-009 m_axi_rready SHALL be 1 in ISSUE and DRAIN, and 0 in IDLE and DONE.

REQ-010 Beat counting SHALL use the rvalid&rready handshake, not rlast.

REQ-011 Each accepted beat k (k = 0..N-1) SHALL produce a buffer write exactly one cycle after the R handshake:
- the selected buffer's wen = 1;
- addr = (start + k) mod 2048;
- data = rdata of that beat.
The unselected buffer's wen SHALL stay 0.

REQ-012 The 11-bit buffer address SHALL wrap from 2047 to 0 with no error indication.

REQ-013 Leave DRAIN for DONE in the cycle after the N-th beat is accepted, coincident with the last buffer write.

REQ-014 DONE SHALL last one cycle with ap_done = 1, then return to IDLE.
- N = 0: ap_done SHALL assert 2 cycles after the ap_start cycle, with no AR or buffer activity.

REQ-015 Internal remaining-beat and outstanding counters SHALL saturate-check so that underflow is impossible.

REQ-016 Simultaneous AR handshake and final-beat R handshake in one cycle SHALL update both counters correctly.

Reset
REQ-017 While areset = 0, all of the following SHALL be 0 and the FSM SHALL be IDLE:
- m_axi_arvalid, m_axi_rready, m_axi_araddr, m_axi_arlen;
- ap_done;
- both buffers' wen, addr and data;
- all counters.

REQ-018 Reset asserted mid-transfer SHALL abort immediately:
- no further buffer writes;
- beats arriving after release SHALL be ignored (rready = 0);
- the next ap_start SHALL begin cleanly.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- N = 4, offset 0x100, ctrl_addr_offset 0x1000, start 5, sel 0, arready = rvalid = 1 -> one AR: addr 0x1100, arlen 3; buffer_1 writes addr 5..8 with matching rdata; ap_done once.
- N = 40, base 0xF00, sel 1 -> ARs: (0xF00, len 3), (0x1000, len 15), (0x1400, len 15), (0x1800, len 3); 40 writes on buffer_2 only.
- N = 3, start 2046 -> buffer writes at addresses 2046, 2047, 0.
- N = 0 -> ap_done 2 cycles after ap_start; no arvalid, no wen.
- arready = 1, rvalid held 0, N = 96 -> exactly 4 ARs issued then arvalid = 0; after releasing rvalid with random stalls, all 96 writes and one ap_done occur.
- areset pulsed low during the scenario 2 transfer, then ap_start with N = 2 -> outputs 0 during reset; the new transfer completes with exactly 2 writes.
